hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 19 +
 rtl/hazard_ctrl_sat_counter.sv | 18 +
 rtl/hazard_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: control FSM states, register-index type and
// the hardwired-zero register constant.
package hazard_ctrl_pkg;

   typedef enum logic [2:0] {IDLE, RUN, FREEZE, DRAIN, DONE} state_t;

   typedef logic [4:0] reg_idx_t;

   localparam reg_idx_t X0 = 5'd0;

   // A load writing x0 never produces a usable value, so it cannot cause a hazard.
   function automatic logic is_load_use(input logic     mem_read,
                                        input reg_idx_t ex_rd,
                                        input reg_idx_t id_rs1,
                                        input reg_idx_t id_rs2);
      return mem_read && (ex_rd != X0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
   endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Width-parameterised event counter that sticks at its maximum value.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (en && (count != '1))
         count <= count + W'(1);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/halt flushes, memory
// freezes, halt drain sequencing and statistics counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int CNT_W     = 16,
   parameter int DRAIN_CYC = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  reg_idx_t         IFID_RS1_i,
   input  reg_idx_t         IFID_RS2_i,
   input  logic             IDEX_MemRead_i,
   input  reg_idx_t         IDEX_RD_i,
   input  logic             branch_taken_i,
   input  logic             halt_i,
   input  logic             mem_stall_i,
   output logic             PCWrite_o,
   output logic             IFIDWrite_o,
   output logic             IFIDFlush_o,
   output logic             IDEX_Bubble_o,
   output logic             Freeze_o,
   output logic             done_o,
   output logic [CNT_W-1:0] lu_cnt_o,
   output logic [CNT_W-1:0] frz_cnt_o,
   output logic [CNT_W-1:0] fl_cnt_o
);

   localparam int DW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

   state_t        state, next_state;
   state_t        ret_state, next_ret;
   state_t        eff_state;
   logic [DW-1:0] drain_cnt, next_drain;
   logic          stall, load_use;
   logic          lu_en, fl_en;

   // ret_state remembers where FREEZE was entered so the thaw cycle behaves as that state.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= IDLE;
         ret_state <= IDLE;
         drain_cnt <= '0;
         done_o    <= 1'b0;
      end else begin
         state     <= next_state;
         ret_state <= next_ret;
         drain_cnt <= next_drain;
         done_o    <= (next_state == DONE);
      end
   end

   assign eff_state = (state == FREEZE) ? ret_state : state;
   assign stall     = mem_stall_i && ((eff_state == RUN) || (eff_state == DRAIN));
   assign load_use  = is_load_use(IDEX_MemRead_i, IDEX_RD_i, IFID_RS1_i, IFID_RS2_i);

   always_comb begin
      next_state    = state;
      next_ret      = ret_state;
      next_drain    = drain_cnt;
      PCWrite_o     = 1'b0;
      IFIDWrite_o   = 1'b0;
      IFIDFlush_o   = 1'b0;
      IDEX_Bubble_o = 1'b0;
      Freeze_o      = 1'b0;
      lu_en         = 1'b0;
      fl_en         = 1'b0;

      if (stall) begin
         Freeze_o   = 1'b1;
         next_state = FREEZE;
         next_ret   = eff_state;
      end else begin
         unique case (eff_state)
            IDLE: begin
               Freeze_o = 1'b1;
               if (start_i)
                  next_state = RUN;
            end
            RUN: begin
               next_state = RUN;
               if (load_use) begin
                  IDEX_Bubble_o = 1'b1;
                  lu_en         = 1'b1;
               end else if (halt_i) begin
                  IFIDWrite_o = 1'b1;
                  IFIDFlush_o = 1'b1;
                  next_drain  = DW'(DRAIN_CYC);
                  next_state  = DRAIN;
               end else if (branch_taken_i) begin
                  PCWrite_o   = 1'b1;
                  IFIDWrite_o = 1'b1;
                  IFIDFlush_o = 1'b1;
                  fl_en       = 1'b1;
               end else begin
                  PCWrite_o   = 1'b1;
                  IFIDWrite_o = 1'b1;
               end
            end
            DRAIN: begin
               IFIDWrite_o = 1'b1;
               IFIDFlush_o = 1'b1;
               next_drain  = drain_cnt - DW'(1);
               next_state  = (drain_cnt == DW'(1)) ? DONE : DRAIN;
            end
            DONE: begin
               Freeze_o = 1'b1;
            end
            default: begin
               Freeze_o   = 1'b1;
               next_state = IDLE;
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_lu_cnt (
      .clk   (clk_i),
      .rst_n (rst_i),
      .en    (lu_en),
      .count (lu_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_frz_cnt (
      .clk   (clk_i),
      .rst_n (rst_i),
      .en    (stall),
      .count (frz_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_fl_cnt (
      .clk   (clk_i),
      .rst_n (rst_i),
      .en    (fl_en),
      .count (fl_cnt_o)
   );

endmodule
